// File: rtl/round_key_add.sv
// Mini-AES key addition: XORs the Mix_column state with a round key produced by an
// on-chip sequential key schedule. Optional macro ROUND_KEY_ADD_ERR_EN adds a sticky load_err output.
module round_key_add #(
    parameter logic [3:0] RCON1 = 4'b0001,
    parameter logic [3:0] RCON2 = 4'b0010
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       key_load,
    input  logic [3:0] k0,
    input  logic [3:0] k1,
    input  logic [3:0] k2,
    input  logic [3:0] k3,
    input  logic [1:0] round_sel,
    input  logic       load,
    input  logic [3:0] c0,
    input  logic [3:0] c1,
    input  logic [3:0] c2,
    input  logic [3:0] c3,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       key_ready,
    output logic       done
`ifdef ROUND_KEY_ADD_ERR_EN
    ,
    output logic       load_err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    function automatic logic [3:0] f_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;
            4'h1: y = 4'h4;
            4'h2: y = 4'hD;
            4'h3: y = 4'h1;
            4'h4: y = 4'h2;
            4'h5: y = 4'hF;
            4'h6: y = 4'hB;
            4'h7: y = 4'h8;
            4'h8: y = 4'h3;
            4'h9: y = 4'hA;
            4'hA: y = 4'h6;
            4'hB: y = 4'hC;
            4'hC: y = 4'h5;
            4'hD: y = 4'h9;
            4'hE: y = 4'h0;
            default: y = 4'h7;
        endcase
        return y;
    endfunction

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;
    logic [3:0] r_w [0:11];
    logic [3:0] r_d [0:3];
    logic       r_done;

    logic [3:0] w_key_in [0:3];
    logic [3:0] w_c      [0:3];
    logic [3:0] w_key_sel[0:3];
    logic [3:0] w_idx;
    logic [3:0] w_prev;
    logic [3:0] w_back;
    logic [3:0] w_new_word;
    logic       w_expanding;
    logic       w_accept;

    assign w_key_in[0] = k0;
    assign w_key_in[1] = k1;
    assign w_key_in[2] = k2;
    assign w_key_in[3] = k3;
    assign w_c[0]      = c0;
    assign w_c[1]      = c1;
    assign w_c[2]      = c2;
    assign w_c[3]      = c3;

    // ---------------- key schedule: one word per EXPAND edge ----------------
    assign w_idx  = 4'(r_cnt) + 4'd4;
    assign w_prev = r_w[w_idx - 4'd1];
    assign w_back = r_w[w_idx - 4'd4];

    always_comb begin
        w_new_word = w_back ^ w_prev;
        if (r_cnt == 3'd0) begin
            w_new_word = w_back ^ f_sbox(w_prev) ^ RCON1;
        end else if (r_cnt == 3'd4) begin
            w_new_word = w_back ^ f_sbox(w_prev) ^ RCON2;
        end
    end

    assign w_expanding = (r_state == EXPAND) && !key_load;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (key_load) begin
            w_state_next = EXPAND;
            w_cnt_next   = 3'd0;
        end else begin
            case (r_state)
                EXPAND: begin
                    w_cnt_next = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_state_next = READY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < 12; i++) begin
                r_w[i] <= 4'h0;
            end
        end else if (key_load) begin
            for (int i = 0; i < 4; i++) begin
                r_w[i] <= w_key_in[i];
            end
        end else if (w_expanding) begin
            r_w[w_idx] <= w_new_word;
        end
    end

    assign key_ready = (r_state == READY);

    // ---------------- data path ----------------
    // key_load on the same edge takes priority, so a coincident load is dropped.
    assign w_accept = load && key_ready && !key_load;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key_sel
        always_comb begin
            case (round_sel)
                2'd0:    w_key_sel[gi] = r_w[gi];
                2'd1:    w_key_sel[gi] = r_w[gi + 4];
                2'd2:    w_key_sel[gi] = r_w[gi + 8];
                default: w_key_sel[gi] = 4'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_d[i] <= 4'h0;
            end
        end else begin
            r_done <= w_accept;
            if (w_accept) begin
                for (int i = 0; i < 4; i++) begin
                    r_d[i] <= w_c[i] ^ w_key_sel[i];
                end
            end
        end
    end

    assign d0   = r_d[0];
    assign d1   = r_d[1];
    assign d2   = r_d[2];
    assign d3   = r_d[3];
    assign done = r_done;

`ifdef ROUND_KEY_ADD_ERR_EN
    logic r_load_err;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_load_err <= 1'b0;
        end else if (load && (key_load || !key_ready)) begin
            r_load_err <= 1'b1;
        end else if (key_load) begin
            r_load_err <= 1'b0;
        end
    end

    assign load_err = r_load_err;
`endif

endmodule

// File: tb/tb_round_key_add.sv
// Directed bench for round_key_add: key schedule timing, round-key XOR for K0..K2,
// pass-through, dropped loads, back-to-back loads and reset during expansion.
module tb_round_key_add;

    logic       clk = 1'b0;
    logic       nrst;
    logic       key_load;
    logic [3:0] k0, k1, k2, k3;
    logic [1:0] round_sel;
    logic       load;
    logic [3:0] c0, c1, c2, c3;
    logic [3:0] d0, d1, d2, d3;
    logic       key_ready;
    logic       done;
`ifdef ROUND_KEY_ADD_ERR_EN
    logic       load_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_edges;

    always #5 clk = ~clk;

    round_key_add dut (
        .clk      (clk),
        .nrst     (nrst),
        .key_load (key_load),
        .k0       (k0),
        .k1       (k1),
        .k2       (k2),
        .k3       (k3),
        .round_sel(round_sel),
        .load     (load),
        .c0       (c0),
        .c1       (c1),
        .c2       (c2),
        .c3       (c3),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .key_ready(key_ready),
        .done     (done)
`ifdef ROUND_KEY_ADD_ERR_EN
        ,
        .load_err (load_err)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input logic [15:0] c);
        {c0, c1, c2, c3} = c;
    endtask

    task automatic key_edge(input logic [15:0] k);
        {k0, k1, k2, k3} = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    // Counts edges after the key_load edge until key_ready, bounded at 20.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (key_ready) break;
        end
    endtask

    task automatic do_load(input logic [1:0] rs, input logic [15:0] c);
        round_sel = rs;
        set_c(c);
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    function automatic logic [15:0] dout();
        return {d0, d1, d2, d3};
    endfunction

    initial begin
        nrst = 1'b0; key_load = 1'b0; load = 1'b0; round_sel = 2'd0;
        {k0, k1, k2, k3} = 16'h0; set_c(16'h0);
        step(); step();
        chk("reset_d", dout(), 16'h0000);
        chk("reset_done", {15'd0, done}, 16'd0);
        chk("reset_key_ready", {15'd0, key_ready}, 16'd0);
`ifdef ROUND_KEY_ADD_ERR_EN
        chk("reset_load_err", {15'd0, load_err}, 16'd0);
`endif
        nrst = 1'b1;

        // Key C,3,F,0: K0=C3F0, K1=30FF, K2=6696
        key_edge(16'hC3F0);
        wait_ready(n_edges);
        chk("expand_latency", 16'(n_edges), 16'd8);

        do_load(2'd0, 16'h9C63);
        chk("k0_done", {15'd0, done}, 16'd1);
        chk("k0_d", dout(), 16'h5F93);
        step();
        chk("k0_done_drop", {15'd0, done}, 16'd0);
        chk("k0_d_hold", dout(), 16'h5F93);

        do_load(2'd1, 16'h0000);
        chk("k1_d", dout(), 16'h30FF);
        do_load(2'd2, 16'h0000);
        chk("k2_d", dout(), 16'h6696);
        do_load(2'd2, 16'h1234);
        chk("k2_d_b", dout(), 16'h74A2);

        // Back-to-back pass-through loads
        round_sel = 2'd3;
        load = 1'b1;
        set_c(16'h1234); step();
        chk("b2b1_done", {15'd0, done}, 16'd1);
        chk("b2b1_d", dout(), 16'h1234);
        set_c(16'h5678); step();
        chk("b2b2_done", {15'd0, done}, 16'd1);
        chk("b2b2_d", dout(), 16'h5678);
        set_c(16'hABCD); step();
        chk("b2b3_done", {15'd0, done}, 16'd1);
        chk("b2b3_d", dout(), 16'hABCD);
        load = 1'b0;
        step();
        chk("b2b_end_done", {15'd0, done}, 16'd0);

        // load coincident with key_load (in READY): dropped, keys invalidated
        round_sel = 2'd0; set_c(16'hFFFF);
        {k0, k1, k2, k3} = 16'h1234;
        key_load = 1'b1; load = 1'b1;
        step();
        key_load = 1'b0;
        chk("coinc_done", {15'd0, done}, 16'd0);
        chk("coinc_d", dout(), 16'hABCD);
        chk("coinc_key_ready", {15'd0, key_ready}, 16'd0);
`ifdef ROUND_KEY_ADD_ERR_EN
        chk("coinc_load_err", {15'd0, load_err}, 16'd1);
`endif
        // load during EXPAND: dropped
        step();
        load = 1'b0;
        chk("expand_load_done", {15'd0, done}, 16'd0);
        chk("expand_load_d", dout(), 16'hABCD);
`ifdef ROUND_KEY_ADD_ERR_EN
        chk("expand_load_err", {15'd0, load_err}, 16'd1);
`endif
        wait_ready(n_edges);
        chk("expand_latency2", 16'(n_edges + 1), 16'd8);

        // Key 1,2,3,4: K1=2037, K2=88BC
        do_load(2'd1, 16'h0000);
        chk("k1b_d", dout(), 16'h2037);
        do_load(2'd2, 16'hFFFF);
        chk("k2b_d", dout(), 16'h7743);

        // Key 0,0,0,0 then clear load_err with a clean key_load
        key_edge(16'h0000);
`ifdef ROUND_KEY_ADD_ERR_EN
        chk("clear_load_err", {15'd0, load_err}, 16'd0);
`endif
        wait_ready(n_edges);
        chk("expand_latency3", 16'(n_edges), 16'd8);
        do_load(2'd1, 16'h1234);
        chk("k1c_d", dout(), 16'hEDCB);
        do_load(2'd2, 16'h0000);
        chk("k2c_d", dout(), 16'hA5A5);
        do_load(2'd0, 16'h9C63);
        chk("k0c_d", dout(), 16'h9C63);

        // Reset on the 4th EXPAND edge
        key_edge(16'hC3F0);
        step(); step(); step();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        chk("rst_mid_d", dout(), 16'h0000);
        chk("rst_mid_done", {15'd0, done}, 16'd0);
        chk("rst_mid_key_ready", {15'd0, key_ready}, 16'd0);
        do_load(2'd3, 16'h1111);
        chk("rst_load_done", {15'd0, done}, 16'd0);
        chk("rst_load_d", dout(), 16'h0000);
        repeat (10) step();
        chk("rst_stay_idle", {15'd0, key_ready}, 16'd0);

        key_edge(16'hC3F0);
        wait_ready(n_edges);
        chk("expand_latency4", 16'(n_edges), 16'd8);
        do_load(2'd2, 16'h0000);
        chk("post_rst_k2_d", dout(), 16'h6696);
        chk("post_rst_done", {15'd0, done}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
